// File: rtl/mask_bit_deposit_pkg.sv
// Shared definitions for the mask bit deposit (scatter) unit.
// Holds the FSM state encoding and the compile-time helpers that turn the
// constant mask into a free-position table.
package mask_bit_deposit_pkg;

  // Widest CONST_MSK the helper functions can inspect.
  localparam int MAX_WIDTH = 256;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // Number of zero (free) bits in the low 'width' bits of msk.
  function automatic int count_free(input logic [MAX_WIDTH-1:0] msk,
                                    input int width);
    int n;
    n = 0;
    for (int i = 0; i < width; i++) begin
      if (!msk[i]) n++;
    end
    return n;
  endfunction

  // Bit position of the k-th zero bit of msk, counting upward from bit 0.
  function automatic int free_pos(input logic [MAX_WIDTH-1:0] msk,
                                  input int width,
                                  input int k);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int i = 0; i < width; i++) begin
      if (!msk[i]) begin
        if (seen == k) pos = i;
        seen++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/mask_bit_deposit.sv
// Mask bit deposit: rebuilds a WIDTH-bit word from a serial LSB-first stream
// of its free bits, filling constant positions from CONST_VAL.
// Optional feature macro: MASK_BIT_DEPOSIT_ORFLAG_EN adds a registered
// out_any flag equal to the OR of the assembled word.
module mask_bit_deposit
  import mask_bit_deposit_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] CONST_MSK = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] CONST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
  ,
  output logic             out_any
`endif
);

  localparam int NFREE = count_free(MAX_WIDTH'(CONST_MSK), WIDTH);
  localparam int CNT_W = (NFREE > 0) ? $clog2(NFREE + 1) : 1;

  // Word seen after reset and after each output handshake: constants in
  // place, free positions cleared.
  localparam logic [WIDTH-1:0] RST_DATA = CONST_VAL & CONST_MSK;

  generate
    if (NFREE == 0) begin : g_const

      logic valid_q;

      // With nothing to collect the word is always ready once reset drops.
      always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= 1'b1;
      end

      assign in_ready  = 1'b0;
      assign out_valid = valid_q;
      assign out_data  = CONST_VAL;
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
      assign out_any   = |RST_DATA;
`endif

    end else begin : g_fsm

      state_t             state_q, state_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic [WIDTH-1:0]   data_q, data_d;
      logic [WIDTH-1:0]   wr_sel;
      logic [WIDTH-1:0]   pos_sel [NFREE];

      // One-hot write mask for every stream index, fixed at elaboration.
      for (genvar k = 0; k < NFREE; k++) begin : g_pos
        localparam logic [WIDTH-1:0] SEL =
          WIDTH'(1) << free_pos(MAX_WIDTH'(CONST_MSK), WIDTH, k);
        assign pos_sel[k] = SEL;
      end

      // Decode the counter into the one-hot position the next bit lands in.
      always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NFREE; k++) begin
          if (cnt_q == CNT_W'(k)) wr_sel = pos_sel[k];
        end
      end

      // Next-state, datapath update and handshake outputs.
      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
          COLLECT: begin
            in_ready = 1'b1;
            if (in_valid) begin
              data_d = (data_q & ~wr_sel) | ({WIDTH{in_bit}} & wr_sel);
              if (cnt_q == CNT_W'(NFREE - 1)) begin
                cnt_d   = '0;
                state_d = FULL;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          FULL: begin
            out_valid = 1'b1;
            if (out_ready) begin
              state_d = COLLECT;
              data_d  = RST_DATA;
            end
          end
          default: begin
            state_d = COLLECT;
          end
        endcase
      end

      // State, counter and word registers; reset wins over any handshake.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= COLLECT;
          cnt_q   <= '0;
          data_q  <= RST_DATA;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          data_q  <= data_d;
        end
      end

      assign out_data = data_q;

`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
      logic any_q;

      // OR flag tracks the word register; constant ones keep it high.
      always_ff @(posedge clk) begin
        if (rst) any_q <= |RST_DATA;
        else     any_q <= |data_d;
      end

      assign out_any = any_q;
`endif

    end
  endgenerate

endmodule

// File: tb/tb_mask_bit_deposit.sv
// Testbench for mask_bit_deposit: a table of words streamed through an
// 8-bit mixed-mask instance and scored at the output handshake, plus
// hand-written sequences for backpressure, mid-word reset, the all-constant
// and all-free masks, and (with MASK_BIT_DEPOSIT_ORFLAG_EN) the OR flag.
module tb_mask_bit_deposit;

  typedef struct {
    logic [3:0] bits;
    logic [2:0] gap;
    logic [7:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;

  logic       a_in_valid, a_in_ready, a_in_bit, a_out_valid, a_out_ready;
  logic [7:0] a_out_data;
  logic       f_in_valid, f_in_ready, f_in_bit, f_out_valid, f_out_ready;
  logic [7:0] f_out_data;
  logic       z_in_valid, z_in_ready, z_in_bit, z_out_valid, z_out_ready;
  logic [3:0] z_out_data;
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
  logic       o_in_valid, o_in_ready, o_in_bit, o_out_valid, o_out_ready;
  logic [7:0] o_out_data;
  logic       a_out_any, f_out_any, z_out_any, o_out_any;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] sb_q[$];
  vec_t       vecs[6];

  mask_bit_deposit #(.WIDTH(8), .CONST_MSK(8'hA5), .CONST_VAL(8'h81)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    , .out_any(a_out_any)
`endif
  );

  mask_bit_deposit #(.WIDTH(8), .CONST_MSK(8'hFF), .CONST_VAL(8'h3C)) dut_f (
    .clk(clk), .rst(rst),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_bit(f_in_bit),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data)
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    , .out_any(f_out_any)
`endif
  );

  mask_bit_deposit #(.WIDTH(4), .CONST_MSK(4'h0), .CONST_VAL(4'h0)) dut_z (
    .clk(clk), .rst(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_bit(z_in_bit),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data)
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    , .out_any(z_out_any)
`endif
  );

`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
  mask_bit_deposit #(.WIDTH(8), .CONST_MSK(8'h0F), .CONST_VAL(8'h00)) dut_o (
    .clk(clk), .rst(rst),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_bit(o_in_bit),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data),
    .out_any(o_out_any)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Score every word of dut_a at the cycle its output handshake completes.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && a_out_valid && a_out_ready) begin
      checkOutput("sb_queue_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("sb_word", a_out_data, e);
      end
    end
  end

  task automatic sendBitA(input logic b);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_bit   = b;
    while (!a_in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) checkOutput("in_ready_timeout", a_in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_q.push_back(v.exp_data);
    for (int j = 0; j < 4; j++) begin
      sendBitA(v.bits[j]);
      if (j < 3 && v.gap[j]) begin
        a_in_valid = 1'b0;
        a_in_bit   = ~a_in_bit;
        @(posedge clk); #1;
        checkOutput("gap_out_valid", a_out_valid, 0);
      end
    end
    a_in_valid = 1'b0;
    checkOutput("latency_out_valid", a_out_valid, 1);
    checkOutput("full_in_ready", a_in_ready, 0);
  endtask

  task automatic drainA();
    int n;
    n = 0;
    a_out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checkOutput("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    a_out_ready = 1'b0;
    checkOutput("clear_out_valid", a_out_valid, 0);
    checkOutput("clear_out_data", a_out_data, 8'h81);
    checkOutput("clear_in_ready", a_in_ready, 1);
  endtask

  initial begin
    vec_t bp;
    logic [3:0] zbits;

    vecs[0] = '{bits: 4'b1101, gap: 3'b000, exp_data: 8'hD3};
    vecs[1] = '{bits: 4'b0000, gap: 3'b101, exp_data: 8'h81};
    vecs[2] = '{bits: 4'b1111, gap: 3'b000, exp_data: 8'hDB};
    vecs[3] = '{bits: 4'b0010, gap: 3'b010, exp_data: 8'h89};
    vecs[4] = '{bits: 4'b1000, gap: 3'b000, exp_data: 8'hC1};
    vecs[5] = '{bits: 4'b0011, gap: 3'b111, exp_data: 8'h8B};

    rst = 1'b1;
    a_in_valid = 0; a_in_bit = 0; a_out_ready = 0;
    f_in_valid = 0; f_in_bit = 0; f_out_ready = 0;
    z_in_valid = 0; z_in_bit = 0; z_out_ready = 0;
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    o_in_valid = 0; o_in_bit = 0; o_out_ready = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_a_out_valid", a_out_valid, 0);
    checkOutput("rst_a_out_data", a_out_data, 8'h81);
    checkOutput("rst_a_in_ready", a_in_ready, 1);
    checkOutput("rst_f_out_valid", f_out_valid, 0);
    checkOutput("rst_f_out_data", f_out_data, 8'h3C);
    checkOutput("rst_f_in_ready", f_in_ready, 0);
    checkOutput("rst_z_in_ready", z_in_ready, 1);
    checkOutput("rst_z_out_data", z_out_data, 4'h0);
`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    checkOutput("rst_a_out_any", a_out_any, 1);
    checkOutput("rst_o_out_any", o_out_any, 0);
    checkOutput("rst_o_out_data", o_out_data, 8'h00);
`endif

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      drainA();
    end

    // Hold the word under backpressure while input keeps offering bits.
    bp = '{bits: 4'b1101, gap: 3'b000, exp_data: 8'hD3};
    applyStimulus(bp);
    a_in_valid = 1'b1;
    a_in_bit   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_data", a_out_data, 8'hD3);
      checkOutput("bp_in_ready", a_in_ready, 0);
      checkOutput("bp_out_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    checkOutput("release_out_valid", a_out_valid, 0);
    checkOutput("release_out_data", a_out_data, 8'h81);
    checkOutput("release_in_ready", a_in_ready, 1);
    checkOutput("release_sb_empty", sb_q.size(), 0);

    // Reset in the middle of a word, with a bit offered in the same cycle.
    sendBitA(1'b1);
    sendBitA(1'b1);
    checkOutput("partial_out_data", a_out_data, 8'h8B);
    a_in_valid = 1'b1;
    a_in_bit   = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    a_in_valid = 1'b0;
    checkOutput("midrst_out_data", a_out_data, 8'h81);
    checkOutput("midrst_out_valid", a_out_valid, 0);
    checkOutput("midrst_in_ready", a_in_ready, 1);
    bp = '{bits: 4'b0000, gap: 3'b000, exp_data: 8'h81};
    applyStimulus(bp);
    drainA();

    // All-constant mask: output word is permanently valid.
    for (int i = 0; i < 8; i++) begin
      f_out_ready = 1'($urandom_range(0, 1));
      f_in_valid  = 1'($urandom_range(0, 1));
      f_in_bit    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput("const_out_valid", f_out_valid, 1);
      checkOutput("const_out_data", f_out_data, 8'h3C);
      checkOutput("const_in_ready", f_in_ready, 0);
    end

    // All-free mask with in_valid toggling; idle cycles carry wrong bits.
    zbits = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      z_in_valid = 1'b1;
      z_in_bit   = zbits[j];
      @(posedge clk); #1;
      if (j < 3) begin
        checkOutput("free_early_valid", z_out_valid, 0);
        z_in_valid = 1'b0;
        z_in_bit   = ~zbits[j];
        @(posedge clk); #1;
      end
    end
    z_in_valid = 1'b0;
    checkOutput("free_out_valid", z_out_valid, 1);
    checkOutput("free_out_data", z_out_data, 4'hB);
    z_out_ready = 1'b1;
    @(posedge clk); #1;
    z_out_ready = 1'b0;
    checkOutput("free_clear_valid", z_out_valid, 0);
    checkOutput("free_clear_data", z_out_data, 4'h0);

`ifdef MASK_BIT_DEPOSIT_ORFLAG_EN
    zbits = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      o_in_valid = 1'b1;
      o_in_bit   = zbits[j];
      @(posedge clk); #1;
    end
    o_in_valid = 1'b0;
    checkOutput("orf_zero_valid", o_out_valid, 1);
    checkOutput("orf_zero_data", o_out_data, 8'h00);
    checkOutput("orf_zero_any", o_out_any, 0);
    o_out_ready = 1'b1;
    @(posedge clk); #1;
    o_out_ready = 1'b0;
    zbits = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      o_in_valid = 1'b1;
      o_in_bit   = zbits[j];
      @(posedge clk); #1;
    end
    o_in_valid = 1'b0;
    checkOutput("orf_word_data", o_out_data, 8'h40);
    checkOutput("orf_word_any", o_out_any, 1);
    o_out_ready = 1'b1;
    @(posedge clk); #1;
    o_out_ready = 1'b0;
    checkOutput("orf_clear_any", o_out_any, 0);
    checkOutput("orf_a_any", a_out_any, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
